multibyte_add_seq: RTL and testbench

//  Multi-cycle controller that adds two NBYTES*8-bit operands through one shared
//  8-bit ripple-carry `adder` instance. Each cycle it feeds one byte slice and chains
//  the carry through a register. Lets wide additions reuse the existing 8-bit datapath

---
 rtl/multibyte_add_seq.sv | 145 ++++++++++++++
 tb/tb_multibyte_add_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Wide adder built from one shared 8-bit ripple-carry adder, one byte per cycle.
// Optional subtract mode is enabled by defining MULTIBYTE_ADD_SUB_EN (adds port op).

module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [8:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef MULTIBYTE_ADD_SUB_EN
    input  logic                op,
`endif
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic                done
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  a_lat, b_lat, acc, merged;
    logic [IW-1:0] idx;
    logic          carry;
    logic [7:0]    a_slice, b_slice, add_s;
    logic          add_cout;
    logic          last;
`ifdef MULTIBYTE_ADD_SUB_EN
    logic          op_lat;
`endif

    assign last = (idx == IW'(NBYTES - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        a_slice = a_lat[8*idx +: 8];
        b_slice = b_lat[8*idx +: 8];
`ifdef MULTIBYTE_ADD_SUB_EN
        // Subtraction as a + ~b + 1; the +1 comes from the preset carry register.
        if (op_lat) b_slice = ~b_slice;
`endif
    end

    adder u_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .s    (add_s),
        .cout (add_cout)
    );

    // Final slice is merged here so sum can load in the same edge as the last add.
    always_comb begin
        merged = acc;
        merged[8*idx +: 8] = add_s;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat  <= '0;
            b_lat  <= '0;
            acc    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
            op_lat <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a;
                        b_lat <= b;
                        acc   <= '0;
                        idx   <= '0;
`ifdef MULTIBYTE_ADD_SUB_EN
                        op_lat <= op;
                        carry  <= op ? 1'b1 : cin;
`else
                        carry  <= cin;
`endif
                    end
                end
                RUN: begin
                    acc   <= merged;
                    carry <= add_cout;
                    if (last) begin
                        sum  <= merged;
                        cout <= add_cout;
                        idx  <= '0;
                    end else begin
                        idx  <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq (NBYTES=4): cycle model plus directed vectors.
// Define MULTIBYTE_ADD_SUB_EN for both files to exercise the subtract mode.

module tb_multibyte_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MULTIBYTE_ADD_SUB_EN
        .op    (op),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles since acceptance and the exact wide result.
    int           m_cnt = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    function automatic logic [W:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic ci, input logic sub);
`ifdef MULTIBYTE_ADD_SUB_EN
        if (sub) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
        return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  = 1;
                m_pend = model_result(a, b, cin, op);
            end
        end else if (m_cnt == NB + 1) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == NB + 1) {m_cout, m_sum} = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_sum",  {1'b0, sum}, {1'b0, m_sum});
            check("model_cout", (W+1)'(cout), (W+1)'(m_cout));
            check("model_busy", (W+1)'(busy), (W+1)'(m_cnt >= 1 && m_cnt <= NB));
            check("model_done", (W+1)'(done), (W+1)'(m_cnt == NB + 1));
        end
    end

    // Drives one start in the current cycle, then waits for done with a cycle budget.
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat = 0;
        int busy_cycles = 0;
        bit seen = 1'b0;
        @(negedge clk);
        a = x; b = y; cin = ci; op = sub; start = 1'b1;
        while (!seen && lat < 20) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, (W+1)'(seen), (W+1)'(1));
        check({name, "_latency"}, (W+1)'(lat), (W+1)'(NB + 1));
        check({name, "_busy_cycles"}, (W+1)'(busy_cycles), (W+1)'(NB));
        check({name, "_sum"}, {1'b0, sum}, {1'b0, exp_sum});
        check({name, "_cout"}, (W+1)'(cout), (W+1)'(exp_cout));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_sum",  {1'b0, sum}, '0);
        check("reset_cout", (W+1)'(cout), '0);
        check("reset_busy", (W+1)'(busy), '0);
        check("reset_done", (W+1)'(done), '0);

        run_op("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        run_op("cin1",  32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0);
        run_op("zero",  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        run_op("max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);

        // Starts during RUN and during DONE must be dropped.
        @(negedge clk);
        a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0; op = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("drop_done_seen", (W+1)'(seen), (W+1)'(1));
        a = 32'h7777_7777; b = 32'h1111_1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("drop_sum",  {1'b0, sum}, {1'b0, 32'h0000_0003});
        check("drop_cout", (W+1)'(cout), '0);
        check("drop_idle", (W+1)'(busy), '0);
        repeat (2) @(negedge clk);

        // Reset during the second RUN cycle abandons the operation.
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < NB + 3; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", (W+1)'(seen), '0);
        check("abort_sum", {1'b0, sum}, '0);
        check("abort_cout", (W+1)'(cout), '0);

        run_op("post_rst", 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 32'hDFD1_0456, 1'b0);

`ifdef MULTIBYTE_ADD_SUB_EN
        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_op("sub_ok",     32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        run_op("sub_eq",     32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
        run_op("add_op0",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_000D, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
